// File: rtl/hc161_disp_scan.sv
// hc161_disp_scan: snapshot, overflow flag and multiplexed 7-segment driver
// for a chain of cascaded 74HC161 counters.
//
// The counter outputs are captured on a latch strobe. A sticky overflow flag
// records terminal-count events since the last latch. The snapshot is scanned
// onto a common-anode display one digit per PRESCALE clocks. The seg and an
// outputs are both active-low and registered.
//
// Optional build macro: HC161_DISP_LZB_EN
//   defined   - leading-zero blanking of digits above digit 0
//   undefined - every digit is shown, including leading zeros
module hc161_disp_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  cp,
    input  logic                  mr,
    input  logic [4*DIGITS-1:0]   qin,
    input  logic                  tc_in,
    input  logic                  le,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  ovf
);

    // Counter widths never drop to zero bits, so the degenerate
    // single-digit / every-cycle cases still build cleanly.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] snap_r;
    logic                ovf_r;
    logic [PW-1:0]       presc_r;
    logic [IW-1:0]       idx_r;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;

    logic                tick_s;
    logic [4*DIGITS-1:0] snap_shift_s;
    logic [3:0]          cur_dig_s;
    logic [DIGITS-1:0]   an_next_s;
    logic                slot_off_s;
    logic                out_off_s;

    // Active-high hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'h0:    r = 7'h3F;
            4'h1:    r = 7'h06;
            4'h2:    r = 7'h5B;
            4'h3:    r = 7'h4F;
            4'h4:    r = 7'h66;
            4'h5:    r = 7'h6D;
            4'h6:    r = 7'h7D;
            4'h7:    r = 7'h07;
            4'h8:    r = 7'h7F;
            4'h9:    r = 7'h6F;
            4'hA:    r = 7'h77;
            4'hB:    r = 7'h7C;
            4'hC:    r = 7'h39;
            4'hD:    r = 7'h5E;
            4'hE:    r = 7'h79;
            4'hF:    r = 7'h71;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Digit selection, anode pattern and scan tick for the current index.
    always_comb begin
        tick_s       = (presc_r == PW'(PRESCALE - 1));
        snap_shift_s = snap_r >> {idx_r, 2'b00};
        cur_dig_s    = snap_shift_s[3:0];
        an_next_s    = ~(DIGITS'(1'b1) << idx_r);
    end

`ifdef HC161_DISP_LZB_EN
    logic [DIGITS-1:0] lz_s;
    logic [DIGITS-1:0] lz_shift_s;
    logic              zero_run_s;

    // lz_s[i] is set when digits DIGITS-1 down to i are all zero; digit 0
    // is excluded so that a zero value still shows a single "0".
    always_comb begin
        zero_run_s = 1'b1;
        lz_s       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (snap_r[4*i +: 4] == 4'h0);
            lz_s[i]    = zero_run_s;
        end
        lz_shift_s = lz_s >> idx_r;
        slot_off_s = (idx_r != IW'(0)) & lz_shift_s[0];
    end
`else
    // Every slot is displayed when leading-zero blanking is not built in.
    always_comb begin
        slot_off_s = 1'b0;
    end
`endif

    // Slot is dark when externally blanked or suppressed as a leading zero.
    always_comb begin
        out_off_s = blank | slot_off_s;
    end

    // Snapshot capture on the latch strobe.
    always_ff @(posedge cp) begin
        if (mr) begin
            snap_r <= '0;
        end else if (le) begin
            snap_r <= qin;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Sticky overflow: a terminal count sets it, a latch without tc clears it.
    always_ff @(posedge cp) begin
        if (mr) begin
            ovf_r <= 1'b0;
        end else if (tc_in) begin
            ovf_r <= 1'b1;
        end else if (le) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Prescaler: free-running modulo-PRESCALE counter that paces the scan.
    always_ff @(posedge cp) begin
        if (mr) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Digit index: advances once per prescaler period, modulo DIGITS.
    always_ff @(posedge cp) begin
        if (mr) begin
            idx_r <= '0;
        end else if (tick_s) begin
            if (idx_r == IW'(DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Output register: one cycle behind the index and snapshot.
    always_ff @(posedge cp) begin
        if (mr) begin
            an_r  <= '1;
            seg_r <= 7'h7F;
        end else if (out_off_s) begin
            an_r  <= '1;
            seg_r <= 7'h7F;
        end else begin
            an_r  <= an_next_s;
            seg_r <= ~hex7(cur_dig_s);
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_hc161_disp_scan.sv
// Directed testbench for hc161_disp_scan (DIGITS=4, PRESCALE=4).
// Honours HC161_DISP_LZB_EN when the design is built with it.
module tb_hc161_disp_scan;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    logic        cp    = 1'b0;
    logic        mr    = 1'b1;
    logic [15:0] qin   = 16'h0000;
    logic        tc_in = 1'b0;
    logic        le    = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ovf;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          ecount = 0;
    logic [15:0] shown  = 16'h0000;
    logic [6:0]  seg_tab [16];
    logic [15:0] sweep   [4];

    hc161_disp_scan #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .cp    (cp),
        .mr    (mr),
        .qin   (qin),
        .tc_in (tc_in),
        .le    (le),
        .blank (blank),
        .seg   (seg),
        .an    (an),
        .ovf   (ovf)
    );

    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; ecount counts edges since mr was released, so the
    // displayed slot is ((ecount-1)/PRESCALE) mod DIGITS. shown is the
    // snapshot that the output register sees at the next edge.
    task automatic step(input string tag);
        logic        mr_e, le_e, blank_e;
        logic [15:0] q_e;
        logic [15:0] sh;
        logic [3:0]  nib;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        int          slot;
        @(posedge cp);
        mr_e = mr; le_e = le; blank_e = blank; q_e = qin;
        if (mr_e) ecount = 0;
        else ecount++;
        #1;
        slot = (ecount > 0) ? (((ecount - 1) / PRESCALE) % DIGITS) : 0;
        sh   = shown >> (4 * slot);
        nib  = sh[3:0];
        if (mr_e || blank_e) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            exp_an  = ~(4'b0001 << slot);
            exp_seg = seg_tab[nib];
`ifdef HC161_DISP_LZB_EN
            if (slot > 0 && sh == 16'h0000) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end
`endif
        end
        chk({tag, ".an"},  {12'h000, an},  {12'h000, exp_an});
        chk({tag, ".seg"}, {9'h000, seg},  {9'h000, exp_seg});
        if (mr_e) shown = 16'h0000;
        else if (le_e) shown = q_e;
    endtask

    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        sweep[0] = 16'hFEDC; sweep[1] = 16'hBA98; sweep[2] = 16'h7654; sweep[3] = 16'h3210;

        // Reset held for two edges.
        #2;
        mr = 1'b1;
        step("rst");
        step("rst");
        chk("rst.ovf", {15'h0, ovf}, 16'h0000);
        chk("rst.an_abs", {12'h0, an}, 16'h000F);
        chk("rst.seg_abs", {9'h0, seg}, 16'h007F);

        // Release with a latch of 1234 on the first edge: digit 0 selected,
        // still showing the cleared snapshot.
        mr = 1'b0; qin = 16'h1234; le = 1'b1;
        step("t1_first");
        chk("t1_first.seg_abs", {9'h0, seg}, 16'h0040);
        le = 1'b0;
        repeat (3) step("t1_scan");
        chk("t1_d0.seg_abs", {9'h0, seg}, 16'h0019);
        step("t1_scan");
        chk("t1_d1.an_abs",  {12'h0, an}, 16'h000D);
        chk("t1_d1.seg_abs", {9'h0, seg}, 16'h0030);
        repeat (4) step("t1_scan");
        chk("t1_d2.seg_abs", {9'h0, seg}, 16'h0024);
        repeat (4) step("t1_scan");
        chk("t1_d3.an_abs",  {12'h0, an}, 16'h0007);
        chk("t1_d3.seg_abs", {9'h0, seg}, 16'h0079);
        repeat (4) step("t1_wrap");
        chk("t1_wrap.an_abs", {12'h0, an}, 16'h000E);
        repeat (3) step("t1_scan");

        // Decode sweep over all sixteen hex digits.
        for (int v = 0; v < 4; v++) begin
            qin = sweep[v]; le = 1'b1;
            step("t2_le");
            le = 1'b0;
            repeat (16) step("t2_sweep");
        end

        // Hold: qin changes without le never reach the display.
        qin = 16'h1234; le = 1'b1;
        step("t3_le");
        le = 1'b0; qin = 16'hFFFF;
        repeat (40) step("t3_hold");
        le = 1'b1;
        step("t3_le2");
        le = 1'b0;
        repeat (16) step("t3_new");
        chk("t3_new.seg_abs", {9'h0, seg}, 16'h000E);

        // Sticky overflow.
        chk("t4_idle.ovf", {15'h0, ovf}, 16'h0000);
        tc_in = 1'b1;
        step("t4_tc");
        tc_in = 1'b0;
        chk("t4_set.ovf", {15'h0, ovf}, 16'h0001);
        for (int k = 0; k < 20; k++) begin
            step("t4_hold");
            chk("t4_hold.ovf", {15'h0, ovf}, 16'h0001);
        end
        le = 1'b1;
        step("t4_le");
        le = 1'b0;
        chk("t4_clr.ovf", {15'h0, ovf}, 16'h0000);
        le = 1'b1; tc_in = 1'b1;
        step("t4_both");
        le = 1'b0; tc_in = 1'b0;
        chk("t4_both.ovf", {15'h0, ovf}, 16'h0001);

        // Blank for six edges; the scan keeps running underneath.
        blank = 1'b1;
        repeat (6) step("t5_blank");
        blank = 1'b0;
        repeat (3) step("t5_resume");

        // Reset in the second cycle of digit 2's slot, then restart at digit 0.
        for (int k = 0; k < 16; k++) begin
            if (((ecount / PRESCALE) % DIGITS) == 2 && (ecount % PRESCALE) == 1) break;
            step("t5_adv");
        end
        mr = 1'b1;
        step("t5_mr");
        chk("t5_mr.ovf", {15'h0, ovf}, 16'h0000);
        mr = 1'b0;
        step("t5_restart");
        chk("t5_restart.an_abs", {12'h0, an}, 16'h000E);
        repeat (8) step("t5_restart");

        // Leading-zero behaviour (blanked only when the macro is built in).
        qin = 16'h0070; le = 1'b1;
        step("t6_le");
        le = 1'b0;
        repeat (16) step("t6_0070");
        qin = 16'h0000; le = 1'b1;
        step("t6_le0");
        le = 1'b0;
        repeat (16) step("t6_0000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hc161_disp_scan.md
Name: hc161_disp_scan

Overview:
Downstream display stage for one or more cascaded W_74HC161 counters. It captures the counters' q outputs into a snapshot register on a latch strobe and keeps a sticky record of terminal-count (tc) events. It then time-multiplexes the snapshot onto a common-anode 7-segment display, one digit at a time. The block sits between the counter chain and the board display pins.

Parameters:
DIGITS, 4, number of 4-bit digits scanned (1..8)
PRESCALE, 1000, cp cycles each digit stays selected (>=1)

Ports:
cp  input  1  clock, all state updates on rising edge
mr  input  1  reset, synchronous, active-high
qin  input  4*DIGITS  counter outputs; digit i = qin[4i+3:4i]; digit 0 is the least significant
tc_in  input  1  tc from the most significant counter
le  input  1  latch enable; captures qin into the snapshot
blank  input  1  forces all digits off; scanning continues
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an  output  DIGITS  digit selects, active-low, one-hot, registered
ovf  output  1  sticky flag: tc_in seen since the last latch

Behaviour:
- Every register updates only on the rising edge of cp. mr=1 overrides every other input in the same edge, including mid-scan.
- Values after an mr edge: snapshot=0, ovf=0, prescaler=0, digit index=0, an=all ones (all digits off), seg=7'h7F (blank).
- Snapshot: le=1 at edge N loads qin at edge N. le=0 holds the snapshot. Changes on qin without le never change the display.
- ovf:
  - tc_in=1 at an edge sets ovf.
  - le=1 with tc_in=0 clears ovf.
  - le=1 and tc_in=1 in the same edge leaves ovf=1 (set wins).
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = (prescaler==PRESCALE-1).
  - PRESCALE=1 gives a tick every cycle.
- Digit index: advances on tick and wraps from DIGITS-1 to 0. With DIGITS=1 it stays at 0.
- Output register: each edge (when mr=0) loads an and seg from the current index and snapshot, so outputs lag the index and snapshot by one cycle.
  - an: bit[idx]=0, all other bits 1.
  - seg: active-low hex decode of the snapshot digit at idx.
  - Example: le at edge N updates the snapshot at N; seg shows the new value for the selected digit from edge N+1.
- Hex decode, active-high {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg is the bitwise inverse.
- blank=1 at an edge: an=all ones and seg=7'h7F at that edge. The prescaler and index keep running, so un-blanking resumes at the current index.
- First output after reset: on the first edge with mr=0, an[0]=0 and seg shows digit 0 of the snapshot (value 0, 7'h40).

Optional Feature:
HC161_DISP_LZB_EN
- Defined: leading-zero blanking. Any digit i>0 for which digits DIGITS-1..i of the snapshot are all 0 is blanked: an all ones, seg=7'h7F during its slot. Digit 0 is never blanked, and slot timing is unchanged.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan:
1. Reset and scan (DIGITS=4, PRESCALE=4): mr=1 for 2 cycles -> an=4'b1111, seg=7'h7F, ovf=0. Release mr, qin=16'h1234, le pulse -> an cycles 1110,1101,1011,0111 for 4 cycles each; seg is 7'h19, 7'h30, 7'h24, 7'h79 respectively; index wraps back to 1110.
2. Decode sweep: latch qin=16'hFEDC, then 16'hBA98, 16'h7654, 16'h3210 -> every active-low code matches the decode table, e.g. C=7'h46, F=7'h0E, 0=7'h40.
3. Hold: after latching 16'h1234, change qin to 16'hFFFF with le=0 for 40 cycles -> seg sequence unchanged. Then le for 1 cycle -> all slots show 7'h0E from the next edge.
4. ovf: tc_in 1-cycle pulse -> ovf=1 next edge, held for 20 cycles. le alone -> ovf=0. le and tc_in in the same edge -> ovf=1.
5. blank and reset mid-scan: blank=1 for 6 cycles -> an=1111, seg=7'h7F; on release the index has advanced normally. mr pulse in the middle of digit 2's slot -> an=1111 at that edge, then a restart at digit 0.
6. HC161_DISP_LZB_EN defined, qin=16'h0070 latched -> slots 3 and 2 blank (an=1111, seg=7'h7F), slot 1 seg=7'h78, slot 0 seg=7'h40. qin=16'h0000 -> only slot 0 lit, showing 7'h40.
